proc_mem_port_arbiter: RTL and testbench

- Shares one memory port between the instruction-fetch requester (port 0) and the data-access requester (port 1) of a pipelined core.
- Arbitrates requests round-robin and forwards the winner to the shared port.
- Records the winner's ID in an in-order tag FIFO and routes each returning response back to the requester that issued it.
- Sits between the processor's imem/dmem val/rdy streams and a single-ported memory or cache.

---
 rtl/proc_mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_proc_mem_port_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (port 0) and data (port 1).
// An in-order tag FIFO remembers which requester owns each outstanding response.
module proc_mem_port_arbiter #(
  parameter int p_max_inflight = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req0_val,
  output logic                             req0_rdy,
  input  logic                             req0_type,
  input  logic [31:0]                      req0_addr,
  input  logic [31:0]                      req0_data,
  input  logic                             req1_val,
  output logic                             req1_rdy,
  input  logic                             req1_type,
  input  logic [31:0]                      req1_addr,
  input  logic [31:0]                      req1_data,
  output logic                             resp0_val,
  input  logic                             resp0_rdy,
  output logic [31:0]                      resp0_data,
  output logic                             resp1_val,
  input  logic                             resp1_rdy,
  output logic [31:0]                      resp1_data,
  output logic                             mem_req_val,
  input  logic                             mem_req_rdy,
  output logic                             mem_req_type,
  output logic [31:0]                      mem_req_addr,
  output logic [31:0]                      mem_req_data,
  input  logic                             mem_resp_val,
  output logic                             mem_resp_rdy,
  input  logic [31:0]                      mem_resp_data,
  output logic [$clog2(p_max_inflight):0]  inflight
);
  localparam int PW = $clog2(p_max_inflight);
  localparam int CW = PW + 1;

  logic [p_max_inflight-1:0] r_tags;
  logic [PW-1:0]             r_head;
  logic [PW-1:0]             r_tail;
  logic [CW-1:0]             r_count;
  logic                      r_prio;

  logic w_v0, w_v1, w_grant, w_full, w_empty, w_head_tag, w_push, w_pop;

  // Requests are masked while reset is held so nothing is offered or accepted.
  assign w_v0    = req0_val & reset;
  assign w_v1    = req1_val & reset;
  assign w_full  = (r_count == CW'(p_max_inflight));
  assign w_empty = (r_count == '0);

  always_comb begin
    if (w_v0 && w_v1)  w_grant = r_prio;
    else if (w_v0)     w_grant = 1'b0;
    else if (w_v1)     w_grant = 1'b1;
    else               w_grant = r_prio;
  end

  always_comb begin
    mem_req_type = 1'b0;
    mem_req_addr = '0;
    mem_req_data = '0;
    if (w_v0 || w_v1) begin
      if (w_grant) begin
        mem_req_type = req1_type;
        mem_req_addr = req1_addr;
        mem_req_data = req1_data;
      end else begin
        mem_req_type = req0_type;
        mem_req_addr = req0_addr;
        mem_req_data = req0_data;
      end
    end
  end

  assign mem_req_val = (w_grant ? w_v1 : w_v0) & ~w_full;
  assign req0_rdy    = ~w_grant & mem_req_rdy & ~w_full & reset;
  assign req1_rdy    =  w_grant & mem_req_rdy & ~w_full & reset;
  assign w_push      = mem_req_val & mem_req_rdy;

  assign w_head_tag   = r_tags[r_head];
  assign resp0_val    = mem_resp_val & ~w_empty & ~w_head_tag;
  assign resp1_val    = mem_resp_val & ~w_empty &  w_head_tag;
  assign resp0_data   = mem_resp_data;
  assign resp1_data   = mem_resp_data;
  assign mem_resp_rdy = ~w_empty & (w_head_tag ? resp1_rdy : resp0_rdy);
  assign w_pop        = mem_resp_val & mem_resp_rdy;

  assign inflight = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tags  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_prio  <= 1'b0;
    end else begin
      if (w_push) begin
        r_tags[r_tail] <= w_grant;
        r_tail         <= r_tail + PW'(1);
        r_prio         <= ~w_grant;
      end
      if (w_pop) r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A response with nothing outstanding means the memory side broke the protocol.
  a_resp_while_empty: assert property (@(posedge clk) disable iff (!reset)
    !(mem_resp_val && w_empty))
    else $error("mem_resp_val asserted with no outstanding request");

endmodule

// File: tb/tb_proc_mem_port_arbiter.sv
// Bench for proc_mem_port_arbiter: directed scenarios plus random traffic, checked
// every cycle against a queue-based model and per-port response scoreboards.
module tb_proc_mem_port_arbiter;
  localparam int P = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        req0_val, req0_rdy, req0_type;
  logic [31:0] req0_addr, req0_data;
  logic        req1_val, req1_rdy, req1_type;
  logic [31:0] req1_addr, req1_data;
  logic        resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [31:0] resp0_data, resp1_data;
  logic        mem_req_val, mem_req_rdy, mem_req_type;
  logic [31:0] mem_req_addr, mem_req_data;
  logic        mem_resp_val, mem_resp_rdy;
  logic [31:0] mem_resp_data;
  logic [$clog2(P):0] inflight;

  proc_mem_port_arbiter #(.p_max_inflight(P)) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_type(req0_type),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_type(req1_type),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_data(resp0_data),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_data(resp1_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_type(mem_req_type),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy), .mem_resp_data(mem_resp_data),
    .inflight(inflight)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit mem_hold = 1'b0;
  int mem_lat  = 1;
  int n_resp0  = 0;
  int n_resp1  = 0;

  typedef struct { logic [31:0] data; int due; } mem_ent_t;
  mem_ent_t    pend[$];
  logic [32:0] exp0[$];
  logic [32:0] exp1[$];

  // Model: outstanding owner IDs in issue order, plus the tie-break owner.
  int mq[$];
  bit m_prio = 1'b0;
  bit m_push = 1'b0;
  bit m_pop  = 1'b0;
  bit m_grant = 1'b0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hD00D_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    bit v0, v1, g, full, empty, head, ev, rv0, rv1, mrr;
    logic [32:0] e;
    if (!reset) begin
      mq.delete(); m_prio = 1'b0; pend.delete(); exp0.delete(); exp1.delete();
    end
    v0 = reset && req0_val;
    v1 = reset && req1_val;
    if (v0 && v1)  g = m_prio;
    else if (v0)   g = 1'b0;
    else if (v1)   g = 1'b1;
    else           g = m_prio;
    full  = (mq.size() == P);
    empty = (mq.size() == 0);
    head  = empty ? 1'b0 : (mq[0] != 0);
    ev    = (g ? v1 : v0) && !full;
    chk("mem_req_val", mem_req_val, ev);
    chk("req0_rdy", req0_rdy, !g && mem_req_rdy && !full && reset);
    chk("req1_rdy", req1_rdy,  g && mem_req_rdy && !full && reset);
    chk("inflight", inflight, mq.size());
    if (ev) begin
      chk("mem_req_addr", mem_req_addr, g ? req1_addr : req0_addr);
      chk("mem_req_type", mem_req_type, g ? req1_type : req0_type);
      chk("mem_req_data", mem_req_data, g ? req1_data : req0_data);
    end else if (!v0 && !v1) begin
      chk("idle_addr", mem_req_addr, 0);
      chk("idle_data", mem_req_data, 0);
    end
    rv0 = mem_resp_val && !empty && !head;
    rv1 = mem_resp_val && !empty &&  head;
    mrr = !empty && (head ? resp1_rdy : resp0_rdy);
    chk("resp0_val", resp0_val, rv0);
    chk("resp1_val", resp1_val, rv1);
    chk("mem_resp_rdy", mem_resp_rdy, mrr);
    m_grant = g;
    m_push  = ev && mem_req_rdy;
    m_pop   = mem_resp_val && mrr;
    if (m_push) begin
      logic [31:0] a;
      logic        t;
      a = g ? req1_addr : req0_addr;
      t = g ? req1_type : req0_type;
      pend.push_back('{data: mem_f(a), due: cyc + mem_lat});
      if (g) exp1.push_back({t, mem_f(a)});
      else   exp0.push_back({t, mem_f(a)});
    end
    if (m_pop) begin
      void'(pend.pop_front());
      if (!head) begin
        e = exp0.pop_front();
        n_resp0++;
        if (!e[32]) chk("resp0_route", resp0_data, e[31:0]);
      end else begin
        e = exp1.pop_front();
        n_resp1++;
        if (!e[32]) chk("resp1_route", resp1_data, e[31:0]);
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        mq.push_back(int'(m_grant));
        m_prio = !m_grant;
      end
    end
  end

  // Advance to just after the next rising edge and drive the memory response side.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due <= cyc && !mem_hold) begin
      mem_resp_val  = 1'b1;
      mem_resp_data = pend[0].data;
    end else begin
      mem_resp_val  = 1'b0;
      mem_resp_data = $urandom;
    end
  endtask

  task automatic idle(input int n);
    req0_val = 1'b0; req1_val = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int r0, r1, k;
    req0_val = 0; req0_type = 0; req0_addr = 0; req0_data = 0;
    req1_val = 0; req1_type = 0; req1_addr = 0; req1_data = 0;
    resp0_rdy = 1; resp1_rdy = 1; mem_req_rdy = 1;
    mem_resp_val = 0; mem_resp_data = 0;

    // Reset held: requests are gated.
    req0_val = 1; req0_addr = 32'h200;
    step(); step();
    #1;
    chk("rst_mem_req_val", mem_req_val, 0);
    chk("rst_req0_rdy", req0_rdy, 0);
    chk("rst_inflight", inflight, 0);
    req0_val = 0;
    step();
    reset = 1'b1;

    // Single requester, back-to-back reads, memory one cycle behind.
    r0 = n_resp0; r1 = n_resp1;
    for (int i = 0; i < 3; i++) begin
      req0_val = 1; req0_type = 0; req0_addr = 32'h200 + 32'(4 * i);
      #1;
      chk("t1_addr", mem_req_addr, 32'h200 + 32'(4 * i));
      chk("t1_inflight", inflight, (i == 0) ? 0 : 1);
      step();
    end
    idle(4);
    chk("t1_resp0_count", n_resp0 - r0, 3);
    chk("t1_resp1_count", n_resp1 - r1, 0);

    // Fill the tag FIFO, then release one response.
    mem_hold = 1;
    req0_val = 1; req0_addr = 32'h300;
    for (int i = 0; i < 4; i++) begin
      #1; chk("t2_rdy_fill", req0_rdy, 1);
      step();
    end
    #1;
    chk("t2_inflight_full", inflight, 4);
    chk("t2_rdy_full", req0_rdy, 0);
    mem_hold = 0;
    step();
    #1;
    chk("t2_inflight_a", inflight, 4);
    chk("t2_rdy_same_cycle", req0_rdy, 0);
    mem_hold = 1;
    step();
    #1;
    chk("t2_inflight_b", inflight, 3);
    chk("t2_rdy_next", req0_rdy, 1);
    step();
    #1;
    chk("t2_inflight_c", inflight, 4);
    mem_hold = 0;
    idle(8);
    chk("t2_drained", inflight, 0);

    // Response stalled on the owning port while the other port is ready.
    resp1_rdy = 0; resp0_rdy = 1;
    req1_val = 1; req1_type = 0; req1_addr = 32'h2000;
    #1; chk("t3_req1_rdy", req1_rdy, 1);
    step();
    req1_val = 0;
    #1;
    chk("t3_resp1_val", resp1_val, 1);
    chk("t3_mem_resp_rdy", mem_resp_rdy, 0);
    step();
    #1;
    chk("t3_inflight_hold", inflight, 1);
    resp1_rdy = 1;
    #1;
    chk("t3_mem_resp_rdy_up", mem_resp_rdy, 1);
    step();
    #1;
    chk("t3_inflight_done", inflight, 0);

    // Interleaved grants 0,1,1,0 with three-cycle memory.
    mem_lat = 3;
    r0 = n_resp0; r1 = n_resp1;
    req0_val = 1; req1_val = 0; req0_addr = 32'h400;
    #1; chk("t4_addr0", mem_req_addr, 32'h400); step();
    req0_val = 0; req1_val = 1; req1_addr = 32'h1400;
    #1; chk("t4_addr1", mem_req_addr, 32'h1400); step();
    req1_addr = 32'h1404;
    #1; chk("t4_addr2", mem_req_addr, 32'h1404); step();
    req0_val = 1; req1_val = 0; req0_addr = 32'h404;
    #1; chk("t4_addr3", mem_req_addr, 32'h404); step();
    idle(10);
    chk("t4_resp0_count", n_resp0 - r0, 2);
    chk("t4_resp1_count", n_resp1 - r1, 2);

    // Asynchronous reset with three outstanding, then tie arbitration from port 0.
    mem_lat = 1; mem_hold = 1;
    req0_val = 1; req0_addr = 32'h500;
    step(); step(); step();
    req0_val = 0;
    step();
    #1;
    chk("t5_inflight_pre", inflight, 3);
    #1;
    reset = 1'b0;
    req0_val = 1; req1_val = 1; req0_addr = 32'h200; req1_addr = 32'h1000;
    #1;
    chk("t5_inflight_rst", inflight, 0);
    chk("t5_mem_req_val", mem_req_val, 0);
    chk("t5_req0_rdy", req0_rdy, 0);
    chk("t5_req1_rdy", req1_rdy, 0);
    chk("t5_mem_resp_rdy", mem_resp_rdy, 0);
    mem_hold = 0;
    step(); step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t6_tie_addr", mem_req_addr, (i % 2 == 0) ? 32'h200 : 32'h1000);
      chk("t6_tie_rdy0", req0_rdy, (i % 2 == 0) ? 1 : 0);
      chk("t6_tie_rdy1", req1_rdy, (i % 2 == 0) ? 0 : 1);
      step();
    end
    idle(6);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req0_val = 1'($urandom_range(0, 1)); req0_type = 1'($urandom_range(0, 1));
      req0_addr = $urandom; req0_data = $urandom;
      req1_val = 1'($urandom_range(0, 1)); req1_type = 1'($urandom_range(0, 1));
      req1_addr = $urandom; req1_data = $urandom;
      resp0_rdy = ($urandom_range(0, 3) != 0);
      resp1_rdy = ($urandom_range(0, 3) != 0);
      mem_req_rdy = ($urandom_range(0, 4) != 0);
      mem_hold = ($urandom_range(0, 3) == 0);
      mem_lat = $urandom_range(1, 4);
      step();
    end
    resp0_rdy = 1; resp1_rdy = 1; mem_req_rdy = 1; mem_hold = 0;
    req0_val = 0; req1_val = 0;
    k = 0;
    while (mq.size() > 0 && k < 200) begin
      step();
      k++;
    end
    #1;
    chk("final_inflight", inflight, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
